// File: rtl/prefix_fetch_unit.sv
// Prefetch queue plus prefix accumulator: fills a circular byte queue from memory and
// presents one decoded opcode head (with its prefix state) at a time.
module prefix_fetch_unit #(
    parameter int DEPTH      = 8,
    parameter int MAX_PREFIX = 14,
    parameter int AW         = 32
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   locked,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    input  logic                   mem_ack,
    input  logic [7:0]             mem_data,
    input  logic                   flush,
    input  logic [AW-1:0]          flush_eip,
    input  logic                   defsize,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [8:0]             opcode,
    output logic [AW-1:0]          op_eip,
    output logic [AW-1:0]          op_next,
    output logic [1:0]             rep,
    output logic                   override,
    output logic                   lock,
    output logic                   opsize,
    output logic                   adsize,
    output logic [2:0]             segment,
    output logic                   op_fault,
    output logic [1:0]             dbg_state,
    output logic [$clog2(DEPTH):0] dbg_count
);
    localparam int CW  = $clog2(DEPTH);
    localparam int PCW = $clog2(MAX_PREFIX + 2);
    localparam logic [CW:0]    FULL      = (CW+1)'(DEPTH);
    localparam logic [PCW-1:0] PFX_LIMIT = PCW'(MAX_PREFIX);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PREFIX = 2'd1, S_OPEXT = 2'd2} state_t;

    // Handshakes: a byte moves memory->queue on a cycle with mem_req=1 and mem_ack=1;
    // a head moves to the consumer on a cycle with op_valid=1 and op_ready=1.
    state_t          r_state, w_state_next;
    logic [7:0]      r_queue [DEPTH];
    logic [CW-1:0]   r_head, r_tail;
    logic [CW:0]     r_count;
    logic [AW-1:0]   r_fetch_addr, r_head_addr, r_eip_acc;
    logic            r_flush_rec;
    logic [2:0]      r_acc_seg;
    logic [1:0]      r_acc_rep;
    logic            r_acc_ovr, r_acc_lock, r_acc_opext, r_acc_osz, r_acc_asz;
    logic [PCW-1:0]  r_pfx_cnt;
    logic            r_op_valid, r_op_fault, r_override, r_lock, r_opsize, r_adsize;
    logic [8:0]      r_opcode;
    logic [AW-1:0]   r_op_eip, r_op_next;
    logic [1:0]      r_rep;
    logic [2:0]      r_segment;

    logic [7:0] w_byte;
    logic [2:0] w_seg_val;
    logic       w_is_seg, w_is_osz, w_is_asz, w_is_lock, w_is_rep, w_is_0f, w_is_pfx;
    logic       w_ack, w_consume, w_pfx_byte, w_fault, w_emit, w_accum, w_restart;

    assign w_byte    = r_queue[r_head];
    assign w_restart = !reset_n || (locked && flush);
    assign mem_req   = reset_n && locked && !flush && !r_flush_rec && (r_count < FULL);
    assign mem_addr  = r_fetch_addr;
    assign w_ack     = mem_ack && mem_req;

    always_comb begin
        w_is_seg  = 1'b0;
        w_seg_val = 3'd0;
        w_is_osz  = 1'b0;
        w_is_asz  = 1'b0;
        w_is_lock = 1'b0;
        w_is_rep  = 1'b0;
        w_is_0f   = 1'b0;
        case (w_byte)
            8'h26: begin w_is_seg = 1'b1; w_seg_val = 3'd0; end
            8'h2E: begin w_is_seg = 1'b1; w_seg_val = 3'd1; end
            8'h36: begin w_is_seg = 1'b1; w_seg_val = 3'd2; end
            8'h3E: begin w_is_seg = 1'b1; w_seg_val = 3'd3; end
            8'h64: begin w_is_seg = 1'b1; w_seg_val = 3'd4; end
            8'h65: begin w_is_seg = 1'b1; w_seg_val = 3'd5; end
            8'h66: w_is_osz  = 1'b1;
            8'h67: w_is_asz  = 1'b1;
            8'hF0: w_is_lock = 1'b1;
            8'hF2, 8'hF3: w_is_rep = 1'b1;
            8'h0F: w_is_0f   = 1'b1;
            default: ;
        endcase
        w_is_pfx = w_is_seg | w_is_osz | w_is_asz | w_is_lock | w_is_rep | w_is_0f;
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (w_restart)   r_state <= S_IDLE;
        else if (locked) r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        if (w_emit)       w_state_next = S_IDLE;
        else if (w_accum) w_state_next = w_is_0f ? S_OPEXT : S_PREFIX;
    end

    // FSM: outputs; in OPEXT every byte is the opcode, even a prefix value
    always_comb begin
        w_consume  = locked && !flush && (r_count != '0) && (!r_op_valid || op_ready);
        w_pfx_byte = (r_state != S_OPEXT) && w_is_pfx;
        w_fault    = w_consume && w_pfx_byte && (r_pfx_cnt == PFX_LIMIT);
        w_emit     = w_consume && (!w_pfx_byte || w_fault);
        w_accum    = w_consume && w_pfx_byte && !w_fault;
    end

    always_ff @(posedge clock) begin
        if (locked && w_ack) r_queue[r_tail] <= mem_data;
    end

    always_ff @(posedge clock) begin
        if (w_restart) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fetch_addr <= reset_n ? flush_eip : '0;
            r_head_addr  <= reset_n ? flush_eip : '0;
            r_eip_acc    <= '0;
            r_flush_rec  <= reset_n;
            r_acc_seg    <= 3'd3;
            r_acc_rep    <= 2'b00;
            r_acc_ovr    <= 1'b0;
            r_acc_lock   <= 1'b0;
            r_acc_opext  <= 1'b0;
            r_acc_osz    <= defsize;
            r_acc_asz    <= defsize;
            r_pfx_cnt    <= '0;
            r_op_valid   <= 1'b0;
            r_op_fault   <= 1'b0;
            r_opcode     <= '0;
            r_op_eip     <= '0;
            r_op_next    <= '0;
            r_rep        <= 2'b00;
            r_override   <= 1'b0;
            r_lock       <= 1'b0;
            r_segment    <= 3'd3;
            r_opsize     <= defsize;
            r_adsize     <= defsize;
        end else if (locked) begin
            r_flush_rec <= 1'b0;
            r_count     <= r_count + (CW+1)'(w_ack) - (CW+1)'(w_consume);
            if (w_ack) begin
                r_tail       <= r_tail + CW'(1);
                r_fetch_addr <= r_fetch_addr + AW'(1);
            end
            if (w_consume) begin
                r_head      <= r_head + CW'(1);
                r_head_addr <= r_head_addr + AW'(1);
            end
            // Start address survives queue stalls between prefix bytes
            if (w_consume && r_state == S_IDLE) r_eip_acc <= r_head_addr;
            if (w_accum) begin
                r_pfx_cnt <= r_pfx_cnt + PCW'(1);
                if (w_is_seg)  begin r_acc_seg <= w_seg_val; r_acc_ovr <= 1'b1; end
                if (w_is_osz)  r_acc_osz   <= ~r_acc_osz;
                if (w_is_asz)  r_acc_asz   <= ~r_acc_asz;
                if (w_is_lock) r_acc_lock  <= 1'b1;
                if (w_is_rep)  r_acc_rep   <= w_byte[1:0];
                if (w_is_0f)   r_acc_opext <= 1'b1;
            end
            if (w_emit) begin
                r_op_valid  <= 1'b1;
                r_op_fault  <= w_fault;
                r_opcode    <= {r_acc_opext & ~w_fault, w_byte};
                r_op_eip    <= (r_state == S_IDLE) ? r_head_addr : r_eip_acc;
                r_op_next   <= r_head_addr + AW'(1);
                r_rep       <= r_acc_rep;
                r_override  <= r_acc_ovr;
                r_lock      <= r_acc_lock;
                r_segment   <= r_acc_seg;
                r_opsize    <= r_acc_osz;
                r_adsize    <= r_acc_asz;
                r_acc_seg   <= 3'd3;
                r_acc_rep   <= 2'b00;
                r_acc_ovr   <= 1'b0;
                r_acc_lock  <= 1'b0;
                r_acc_opext <= 1'b0;
                r_acc_osz   <= defsize;
                r_acc_asz   <= defsize;
                r_pfx_cnt   <= '0;
            end else if (r_op_valid && op_ready) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign op_valid  = r_op_valid;
    assign op_fault  = r_op_fault;
    assign opcode    = r_opcode;
    assign op_eip    = r_op_eip;
    assign op_next   = r_op_next;
    assign rep       = r_rep;
    assign override  = r_override;
    assign lock      = r_lock;
    assign segment   = r_segment;
    assign opsize    = r_opsize;
    assign adsize    = r_adsize;
    assign dbg_state = r_state;
    assign dbg_count = r_count;
endmodule

// File: tb/tb_prefix_fetch_unit.sv
// Directed bench for prefix_fetch_unit: memory responder, output monitor and
// an expected-record queue checked field by field.
module tb_prefix_fetch_unit;
    localparam int RW = 83;

    logic        clock = 1'b0;
    logic        reset_n, locked, mem_req, mem_ack, flush, defsize, op_valid, op_ready;
    logic [31:0] mem_addr, flush_eip, op_eip, op_next;
    logic [7:0]  mem_data;
    logic [8:0]  opcode;
    logic [1:0]  rep, dbg_state;
    logic        override, lock, opsize, adsize, op_fault;
    logic [2:0]  segment;
    logic [3:0]  dbg_count;

    prefix_fetch_unit #(.DEPTH(8), .MAX_PREFIX(14), .AW(32)) dut (
        .clock(clock), .reset_n(reset_n), .locked(locked),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .flush(flush), .flush_eip(flush_eip), .defsize(defsize),
        .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
        .op_eip(op_eip), .op_next(op_next), .rep(rep), .override(override),
        .lock(lock), .opsize(opsize), .adsize(adsize), .segment(segment),
        .op_fault(op_fault), .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_mode = 0;
    logic force_ack = 1'b0;
    logic [7:0]    mem [logic [31:0]];
    logic [7:0]    pat [$];
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] got_q [$];
    int            got_c [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk(input logic [8:0] opc, input logic [31:0] eip,
        input logic [31:0] nxt, input logic [1:0] rp, input logic ov, input logic lk,
        input logic os, input logic as_, input logic [2:0] sg, input logic ft);
        return {ft, sg, as_, os, lk, ov, rp, nxt, eip, opc};
    endfunction

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h90;
    endfunction

    // memory responder and output monitor share one process so cyc is coherent
    always @(negedge clock) begin
        cyc++;
        case (ack_mode)
            0:       mem_ack = 1'b0;
            1:       mem_ack = mem_req;
            2:       mem_ack = mem_req && (cyc % 3 == 0);
            default: mem_ack = force_ack;
        endcase
        mem_data = (ack_mode == 3) ? 8'hEE : (mem_ack ? rd(mem_addr) : 8'h00);
        if (reset_n && op_valid && op_ready) begin
            got_q.push_back(mk(opcode, op_eip, op_next, rep, override, lock,
                               opsize, adsize, segment, op_fault));
            got_c.push_back(cyc);
        end
    end

    // driver tasks
    task automatic load(input logic [31:0] base);
        for (int i = 0; i < pat.size(); i++) mem[base + 32'(i)] = pat[i];
    endtask

    task automatic start_at(input logic [31:0] a, input logic ds);
        @(posedge clock); #1;
        flush = 1'b1; flush_eip = a; defsize = ds;
        @(posedge clock); #1;
        flush = 1'b0;
        got_q.delete(); got_c.delete(); exp_q.delete();
    endtask

    task automatic wait_outputs(input int n);
        for (int i = 0; i < 200 && got_q.size() < n; i++) @(posedge clock);
        check("n_outputs", (got_q.size() >= n) ? n : got_q.size(), n);
    endtask

    // scoreboard: full=0 limits the comparison to opcode/addresses/fault
    task automatic compare(input string tag, input int n, input bit full);
        logic [RW-1:0] g, e;
        for (int i = 0; i < n && got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_opcode"}, g[8:0], e[8:0]);
            check({tag, "_eip"},    g[40:9], e[40:9]);
            check({tag, "_next"},   g[72:41], e[72:41]);
            check({tag, "_fault"},  g[82], e[82]);
            if (full) check({tag, "_prefix"}, g[81:73], e[81:73]);
        end
    endtask

    initial begin
        reset_n = 1'b0; locked = 1'b1; flush = 1'b0; flush_eip = '0;
        defsize = 1'b1; op_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_count", dbg_count, 4'd0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_segment", segment, 3'd3);
        check("rst_opcode", opcode, 9'h000);
        check("rst_sizes", {opsize, adsize, rep, override, lock, op_fault}, 7'b1100000);
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_req", mem_req, 1'b1);
        check("post_rst_addr", mem_addr, 32'h0);

        // three NOPs back to back
        op_ready = 1'b1; ack_mode = 1;
        start_at(32'hF8000, 1'b0);
        for (int i = 0; i < 3; i++)
            exp_q.push_back(mk(9'h090, 32'hF8000 + 32'(i), 32'hF8001 + 32'(i),
                               2'b00, 0, 0, 0, 0, 3'd3, 0));
        wait_outputs(3);
        if (got_c.size() >= 3) begin
            check("b2b_1", got_c[1] - got_c[0], 1);
            check("b2b_2", got_c[2] - got_c[1], 1);
        end
        compare("nop", 3, 1);

        pat = '{8'h66, 8'h2E, 8'hF3, 8'hA5}; load(32'h1000);
        start_at(32'h1000, 1'b0);
        exp_q.push_back(mk(9'h0A5, 32'h1000, 32'h1004, 2'b11, 1, 0, 1, 0, 3'd1, 0));
        wait_outputs(1); compare("movs", 1, 1);

        pat = '{8'h0F, 8'h84}; load(32'h2000);
        start_at(32'h2000, 1'b1);
        exp_q.push_back(mk(9'h184, 32'h2000, 32'h2002, 2'b00, 0, 0, 1, 1, 3'd3, 0));
        wait_outputs(1); compare("opext", 1, 1);

        pat = '{8'h66, 8'h66, 8'h90}; load(32'h3000);
        start_at(32'h3000, 1'b1);
        exp_q.push_back(mk(9'h090, 32'h3000, 32'h3003, 2'b00, 0, 0, 1, 1, 3'd3, 0));
        wait_outputs(1); compare("dbl66", 1, 1);

        pat.delete(); for (int i = 0; i < 15; i++) pat.push_back(8'h26); load(32'h4000);
        start_at(32'h4000, 1'b1);
        exp_q.push_back(mk(9'h026, 32'h4000, 32'h400F, 2'b00, 1, 0, 1, 1, 3'd0, 1));
        exp_q.push_back(mk(9'h090, 32'h400F, 32'h4010, 2'b00, 0, 0, 1, 1, 3'd3, 0));
        wait_outputs(2); compare("limit", 1, 0); compare("after_limit", 1, 1);

        pat.delete(); for (int i = 0; i < 14; i++) pat.push_back(8'h26);
        pat.push_back(8'h90); load(32'h5000);
        start_at(32'h5000, 1'b1);
        exp_q.push_back(mk(9'h090, 32'h5000, 32'h500F, 2'b00, 1, 0, 1, 1, 3'd0, 0));
        wait_outputs(1); compare("max_ok", 1, 1);

        pat = '{8'hF3, 8'hF2, 8'h67, 8'hF0, 8'h64, 8'hC3}; load(32'h6000);
        start_at(32'h6000, 1'b0);
        exp_q.push_back(mk(9'h0C3, 32'h6000, 32'h6006, 2'b10, 1, 1, 0, 1, 3'd4, 0));
        wait_outputs(1); compare("groups", 1, 1);

        // slow memory forces the queue empty between prefix bytes
        pat = '{8'h2E, 8'h3E, 8'h90}; load(32'h7000);
        ack_mode = 2;
        start_at(32'h7000, 1'b1);
        exp_q.push_back(mk(9'h090, 32'h7000, 32'h7003, 2'b00, 1, 0, 1, 1, 3'd3, 0));
        wait_outputs(1); compare("stall", 1, 1);

        // consumer stalled: queue saturates, fetch wraps past FFFFFFFF
        op_ready = 1'b0; ack_mode = 1; mem[32'h0] = 8'hC3;
        start_at(32'hFFFF_FFFC, 1'b1);
        repeat (25) @(posedge clock);
        @(negedge clock);
        check("full_count", dbg_count, 4'd8);
        check("full_req", mem_req, 1'b0);
        check("full_addr", mem_addr, 32'h5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_valid", op_valid, 1'b1);
            check("hold_opcode", opcode, 9'h090);
            check("hold_eip", op_eip, 32'hFFFF_FFFC);
        end
        @(posedge clock); #1 op_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(mk(9'h090, 32'hFFFF_FFFC + 32'(i), 32'hFFFF_FFFD + 32'(i),
                               2'b00, 0, 0, 1, 1, 3'd3, 0));
        exp_q.push_back(mk(9'h0C3, 32'h0, 32'h1, 2'b00, 0, 0, 1, 1, 3'd3, 0));
        wait_outputs(5); compare("wrap", 5, 1);

        // flush arriving with an ack and a pending head
        op_ready = 1'b0; mem[32'h9000] = 8'hC3;
        start_at(32'h8000, 1'b1);
        repeat (5) @(posedge clock); #1;
        ack_mode = 3; force_ack = 1'b1; flush = 1'b1; flush_eip = 32'h9000;
        @(negedge clock);
        check("flush_req0", mem_req, 1'b0);
        check("pre_flush_valid", op_valid, 1'b1);
        @(posedge clock); #1 flush = 1'b0; force_ack = 1'b0;
        @(negedge clock);
        check("flush_valid", op_valid, 1'b0);
        check("flush_req1", mem_req, 1'b0);
        check("flush_count", dbg_count, 4'd0);
        @(negedge clock);
        check("flush_req2", mem_req, 1'b1);
        check("flush_addr", mem_addr, 32'h9000);
        @(posedge clock); #1;
        got_q.delete(); got_c.delete(); exp_q.delete();
        ack_mode = 1; op_ready = 1'b1;
        exp_q.push_back(mk(9'h0C3, 32'h9000, 32'h9001, 2'b00, 0, 0, 1, 1, 3'd3, 0));
        wait_outputs(1); compare("flush_restart", 1, 1);

        // reset in the middle of fetching
        @(posedge clock); #1 reset_n = 1'b0;
        @(negedge clock);
        check("midrst_req", mem_req, 1'b0);
        @(posedge clock); #1 reset_n = 1'b1;
        @(negedge clock);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_count", dbg_count, 4'd0);
        check("midrst_valid", op_valid, 1'b0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prefix_fetch_unit.md
PREFIX_FETCH_UNIT -- requirements
Module: prefix_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 8: prefetch queue depth in bytes; power of two, 2..64.
REQ-002 Parameter MAX_PREFIX, default 14: maximum prefix bytes accepted before an opcode.
REQ-003 Parameter AW, default 32: fetch address width.
REQ-004 clock  in  1  system clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 locked  in  1  clock enable; when 0, all state holds.
REQ-007 mem_req  out  1  fetch request.
REQ-008 mem_addr  out  AW  fetch byte address.
REQ-009 mem_ack  in  1  byte valid this cycle; legal only while mem_req=1.
REQ-010 mem_data  in  8  fetched byte, valid with mem_ack.
REQ-011 flush  in  1  discard queue and restart fetch at flush_eip.
REQ-012 flush_eip  in  AW  restart address.
REQ-013 defsize  in  1  default operand/address size (0=16, 1=32).
REQ-014 op_valid  out  1  decoded instruction head available.
REQ-015 op_ready  in  1  consumer accepts head.
REQ-016 opcode  out  9  {opext, opcode byte}.
REQ-017 op_eip  out  AW  address of first byte (first prefix) of the instruction.
REQ-018 op_next  out  AW  address of byte after the opcode.
REQ-019 rep  out  2  last F2/F3 byte[1:0], else 00.
REQ-020 override, lock, opsize, adsize  out  1 each  prefix results.
REQ-021 segment  out  3  0..5 = ES,CS,SS,DS,FS,GS; 3 when no override.
REQ-022 op_fault  out  1  prefix limit exceeded.

Function
REQ-023 Queue: circular, DEPTH bytes, head/tail pointers wrap mod DEPTH; count 0..DEPTH.
REQ-024 mem_req = (count < DEPTH) and not flush and not flush-recovery cycle; mem_addr = fetch pointer; held stable until mem_ack; one outstanding request.
REQ-025 On mem_ack: byte written at tail, tail+1, fetch pointer+1, wrapping 2^AW-1 -> 0.
REQ-026 Ack and consume in same cycle: count unchanged; ack at count=DEPTH-1 makes full, mem_req drops next cycle.
REQ-027 Decoder consumes at most one byte per cycle, only when count>0 and (op_valid=0 or op_ready=1).
REQ-028 First consumed byte of an instruction latches op_eip = head address.
REQ-029 Prefix bytes: 26/2E/36/3E/64/65 set segment (0..5) and override=1; 66 inverts opsize; 67 inverts adsize; F0 sets lock; F2/F3 set rep; 0F sets opext; later prefix of same group overwrites.
REQ-030 Byte after 0F, or any non-prefix byte, is the opcode: output registers load, op_valid=1, op_next = its address+1; accumulators return to segment=3, override=0, rep=00, lock=0, opext=0, opsize=adsize=defsize.
REQ-031 States: IDLE (no prefix accumulated), PREFIX (>=1 prefix), OPEXT (after 0F); IDLE->PREFIX on prefix, ->OPEXT on 0F, ->IDLE on opcode emit.
REQ-032 Prefix limit: (MAX_PREFIX+1)th prefix byte emits op_valid=1, op_fault=1, opcode = that byte, state IDLE; 0F counts as a prefix.
REQ-033 Outputs held stable while op_valid=1 and op_ready=0; op_valid=1 with op_ready=1 and a new opcode byte gives back-to-back output, one per cycle.
REQ-034 flush priority over all: queue count=0, head=tail, fetch pointer and head address = flush_eip, op_valid=0, accumulators default, state IDLE; mem_ack in the flush cycle discarded; mem_req=0 in flush cycle and following cycle.
REQ-035 op_eip for an instruction whose prefixes span a stall (queue empty mid-prefix) remains the first prefix address.

Reset
REQ-036 reset_n=0 (with locked=1): count=0, pointers 0, fetch pointer and head address = 0, state IDLE, op_valid=0, op_fault=0, opcode=0, rep=00, override=0, lock=0, segment=3, opsize=adsize=defsize, mem_req=0 in reset cycle.
REQ-037 Reset mid-request discards in-flight ack; after reset first mem_req addresses 0.

Verification
REQ-038 flush_eip=F8000, bytes 90,90,90, op_ready=1 -> three outputs opcode=090, op_eip F8000/F8001/F8002, back-to-back.
REQ-039 Bytes 66,2E,F3,A5, defsize=0 -> one output opcode=0A5, opsize=1, segment=1, override=1, rep=11, op_eip=start, op_next=start+4.
REQ-040 Bytes 0F,84 -> opcode=184; 66,66,90 -> opsize=defsize.
REQ-041 MAX_PREFIX=14, fifteen 26 bytes -> op_fault=1, opcode=026 on 15th byte.
REQ-042 op_ready=0 with ack every cycle -> count saturates at DEPTH, mem_req=0, outputs stable; fetch at FFFFFFFF wraps to 00000000.
REQ-043 flush asserted with mem_ack and op_valid=1 -> ack byte dropped, op_valid=0 next cycle, mem_req=0 two cycles, then mem_addr=flush_eip.
